// File: rtl/lo_psync_sched.sv
`default_nettype none
// ============================================================================
// Module   : lo_psync_sched
// Purpose  : Sequencer for the per-channel LO divider phase-sync controllers.
//            Walks the enabled channels one at a time. For each channel it
//            pulses the channel's local reset, routes the shared LO I/Q
//            sampler to it, enables it and waits for DONE or a timeout.
//            Failed attempts are retried up to MAX_RETRY extra times.
//            Per-channel pass/fail and an overall done flag are reported as
//            sticky status bits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK       in   1      block clock, rising edge
//   ARST      in   1      asynchronous reset, active high
//   START     in   1      level, sampled in IDLE, begins a sequence
//   ABORT     in   1      level, cancels a sequence in progress
//   CH_MASK   in   NCH    1 = channel takes part in the sequence
//   CH_DONE   in   2*NCH  channel k DONE[1:0] on bits [2k+1:2k]
//                         (bit1 finished, bit0 success)
//   CH_EN     out  NCH    one-hot or zero enable to the channel controllers
//   CH_NRST   out  NCH    active-low local reset to the channel controllers
//   SAMP_SEL  out  3      index of the channel that owns the LO sampler
//   BUSY      out  1      sequence in progress
//   SEQ_DONE  out  1      sticky, sequence completed
//   CH_OK     out  NCH    sticky per-channel success
//   CH_FAIL   out  NCH    sticky per-channel final failure
//   ABORTED   out  1      sticky, last sequence was aborted
// ============================================================================
module lo_psync_sched #(
    parameter int NCH       = 4,
    parameter int MAX_RETRY = 2,
    parameter int RST_CYC   = 4,
    parameter int TO_CYC    = 8192
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [NCH-1:0]   CH_MASK,
    input  logic [2*NCH-1:0] CH_DONE,
    output logic [NCH-1:0]   CH_EN,
    output logic [NCH-1:0]   CH_NRST,
    output logic [2:0]       SAMP_SEL,
    output logic             BUSY,
    output logic             SEQ_DONE,
    output logic [NCH-1:0]   CH_OK,
    output logic [NCH-1:0]   CH_FAIL,
    output logic             ABORTED
);

    // One extra bit on the channel counter so it can hold NCH (end of walk).
    localparam int                c_ch_w      = $clog2(NCH) + 1;
    localparam logic [c_ch_w-1:0] c_ch_inc    = c_ch_w'(1);
    localparam logic [3:0]        c_rst_load  = 4'(RST_CYC - 1);
    localparam logic [15:0]       c_to_last   = 16'(TO_CYC - 1);
    localparam logic [2:0]        c_max_retry = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_RESET  = 3'd2,
        S_ARM    = 3'd3,
        S_WAIT   = 3'd4,
        S_RETRY  = 3'd5,
        S_NEXT   = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t              r_state;
    logic [NCH-1:0]      r_mask;
    logic [c_ch_w-1:0]   r_ch;
    logic [2:0]          r_retry;
    logic [3:0]          r_rst_cnt;
    logic [15:0]         r_to_cnt;

    logic [NCH-1:0]      w_ch_oh;     // one-hot of the current channel
    logic [1:0]          w_done;      // DONE of the current channel only
    logic                w_mask_bit;  // current channel is enabled
    logic                w_ch_end;    // walked past the last channel

    // Decode the current channel; DONE from every other channel is dropped
    // here so stray completions elsewhere can never steer the FSM.
    always_comb begin
        w_ch_oh = '0;
        w_done  = 2'b00;
        for (int k = 0; k < NCH; k++) begin
            if (int'(r_ch) == k) begin
                w_ch_oh[k] = 1'b1;
                w_done     = CH_DONE[2*k +: 2];
            end
        end
        w_mask_bit = |(r_mask & w_ch_oh);
        w_ch_end   = (int'(r_ch) >= NCH);
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_ch      <= '0;
            r_retry   <= '0;
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
            CH_EN     <= '0;
            CH_NRST   <= '1;
            SAMP_SEL  <= '0;
            BUSY      <= 1'b0;
            SEQ_DONE  <= 1'b0;
            CH_OK     <= '0;
            CH_FAIL   <= '0;
            ABORTED   <= 1'b0;
        end else if (ABORT && (r_state != S_IDLE)) begin
            // Abort overrides every transition; partial results are kept.
            r_state <= S_IDLE;
            CH_EN   <= '0;
            CH_NRST <= '1;
            BUSY    <= 1'b0;
            ABORTED <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        SEQ_DONE <= 1'b0;
                        CH_OK    <= '0;
                        CH_FAIL  <= '0;
                        ABORTED  <= 1'b0;
                        r_mask   <= CH_MASK;
                        r_ch     <= '0;
                        r_retry  <= '0;
                        BUSY     <= 1'b1;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_ch_end) begin
                        r_state <= S_FINISH;
                    end else if (!w_mask_bit) begin
                        r_ch <= r_ch + c_ch_inc;
                    end else begin
                        SAMP_SEL  <= 3'(r_ch);
                        CH_NRST   <= ~w_ch_oh;
                        r_rst_cnt <= c_rst_load;
                        r_state   <= S_RESET;
                    end
                end
                S_RESET: begin
                    // Local reset went low on entry; hold it for RST_CYC cycles.
                    if (r_rst_cnt == 4'd0) begin
                        CH_NRST <= '1;
                        r_state <= S_ARM;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 4'd1;
                    end
                end
                S_ARM: begin
                    // Reset released one cycle ago with EN low: lets the
                    // sampler mux settle before the controller starts.
                    CH_EN    <= w_ch_oh;
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // DONE is tested before the timeout so it wins a tie.
                    if (w_done[1]) begin
                        CH_EN <= '0;
                        if (w_done[0]) begin
                            CH_OK   <= CH_OK | w_ch_oh;
                            r_state <= S_NEXT;
                        end else begin
                            r_state <= S_RETRY;
                        end
                    end else if (r_to_cnt == c_to_last) begin
                        CH_EN   <= '0;
                        r_state <= S_RETRY;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_RETRY: begin
                    CH_EN <= '0;
                    if (r_retry < c_max_retry) begin
                        r_retry   <= r_retry + 3'd1;
                        CH_NRST   <= ~w_ch_oh;
                        r_rst_cnt <= c_rst_load;
                        r_state   <= S_RESET;
                    end else begin
                        CH_FAIL <= CH_FAIL | w_ch_oh;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    CH_EN   <= '0;
                    r_retry <= '0;
                    r_ch    <= r_ch + c_ch_inc;
                    r_state <= S_SCAN;
                end
                S_FINISH: begin
                    SEQ_DONE <= 1'b1;
                    BUSY     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lo_psync_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lo_psync_sched
// Purpose  : Self-checking bench for lo_psync_sched. Per-channel responder
//            models return scripted DONE codes after scripted delays; a
//            reference model derives the expected channel order, enable
//            lengths, attempt counts, pass/fail bits and sequence length
//            from the sequencing rules by cycle accounting per state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lo_psync_sched;

    localparam int NCH       = 4;
    localparam int MAX_RETRY = 2;
    localparam int RST_CYC   = 4;
    localparam int TO_CYC    = 8192;
    localparam int MAXA      = MAX_RETRY + 1;
    localparam int R_OK      = 0;
    localparam int R_BAD     = 1;
    localparam int R_NONE    = 2;
    localparam logic [NCH-1:0] ALL1 = '1;

    logic             CLK = 1'b0;
    logic             ARST;
    logic             START;
    logic             ABORT;
    logic [NCH-1:0]   CH_MASK;
    logic [2*NCH-1:0] CH_DONE;
    logic [NCH-1:0]   CH_EN;
    logic [NCH-1:0]   CH_NRST;
    logic [2:0]       SAMP_SEL;
    logic             BUSY;
    logic             SEQ_DONE;
    logic [NCH-1:0]   CH_OK;
    logic [NCH-1:0]   CH_FAIL;
    logic             ABORTED;

    lo_psync_sched #(
        .NCH       (NCH),
        .MAX_RETRY (MAX_RETRY),
        .RST_CYC   (RST_CYC),
        .TO_CYC    (TO_CYC)
    ) u_dut (
        .CLK      (CLK),
        .ARST     (ARST),
        .START    (START),
        .ABORT    (ABORT),
        .CH_MASK  (CH_MASK),
        .CH_DONE  (CH_DONE),
        .CH_EN    (CH_EN),
        .CH_NRST  (CH_NRST),
        .SAMP_SEL (SAMP_SEL),
        .BUSY     (BUSY),
        .SEQ_DONE (SEQ_DONE),
        .CH_OK    (CH_OK),
        .CH_FAIL  (CH_FAIL),
        .ABORTED  (ABORTED)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- channel responder models ----------------
    int   rsp_code [NCH][MAXA];
    int   rsp_dly  [NCH][MAXA];
    int   rsp_att  [NCH];
    int   rsp_cyc  [NCH];
    logic [NCH-1:0] rsp_prev;

    task automatic set_all(input int code, input int dly);
        for (int k = 0; k < NCH; k++)
            for (int a = 0; a < MAXA; a++) begin
                rsp_code[k][a] = code;
                rsp_dly[k][a]  = dly;
            end
    endtask

    // Disabled channels drive random garbage on their DONE pair.
    initial begin
        CH_DONE  = '0;
        rsp_prev = '0;
        for (int k = 0; k < NCH; k++) begin
            rsp_att[k] = 0;
            rsp_cyc[k] = 0;
        end
        forever begin
            @(negedge CLK);
            for (int k = 0; k < NCH; k++) begin
                if (CH_EN[k]) begin
                    rsp_cyc[k]++;
                    if (rsp_att[k] < MAXA && rsp_code[k][rsp_att[k]] != R_NONE &&
                        rsp_cyc[k] == rsp_dly[k][rsp_att[k]])
                        CH_DONE[2*k +: 2] = (rsp_code[k][rsp_att[k]] == R_OK) ? 2'b11 : 2'b10;
                    else if (rsp_cyc[k] == 1)
                        CH_DONE[2*k +: 2] = 2'b00;
                end else begin
                    if (rsp_prev[k])
                        rsp_att[k]++;
                    rsp_cyc[k] = 0;
                    CH_DONE[2*k +: 2] = 2'($urandom_range(0, 3));
                end
                rsp_prev[k] = CH_EN[k];
            end
        end
    end

    // ---------------- output monitor ----------------
    int en_len [NCH];
    int nrst_len [NCH];
    int en_rises [NCH];
    int nrst_falls [NCH];
    int obs_ch[$];
    int obs_len[$];
    logic [NCH-1:0] mon_en_prev;
    logic [NCH-1:0] mon_nrst_prev;

    task automatic clear_obs();
        obs_ch.delete();
        obs_len.delete();
        for (int k = 0; k < NCH; k++) begin
            en_len[k]     = 0;
            nrst_len[k]   = 0;
            en_rises[k]   = 0;
            nrst_falls[k] = 0;
            rsp_att[k]    = 0;
        end
    endtask

    initial begin
        mon_en_prev   = '0;
        mon_nrst_prev = '1;
        clear_obs();
        forever begin
            @(negedge CLK);
            if (ARST) begin
                mon_en_prev   = '0;
                mon_nrst_prev = '1;
                for (int k = 0; k < NCH; k++) begin
                    en_len[k]   = 0;
                    nrst_len[k] = 0;
                end
            end else begin
                if (CH_EN != '0) begin
                    chk("en_onehot", 32'($onehot(CH_EN)), 32'd1);
                    for (int k = 0; k < NCH; k++)
                        if (CH_EN[k])
                            chk("en_vs_samp_sel", 32'(SAMP_SEL), k);
                end
                for (int k = 0; k < NCH; k++) begin
                    if (CH_EN[k]) begin
                        en_len[k]++;
                        if (!mon_en_prev[k])
                            en_rises[k]++;
                    end else if (mon_en_prev[k]) begin
                        obs_ch.push_back(k);
                        obs_len.push_back(en_len[k]);
                        en_len[k] = 0;
                    end
                    if (!CH_NRST[k]) begin
                        nrst_len[k]++;
                        if (mon_nrst_prev[k])
                            nrst_falls[k]++;
                    end else if (!mon_nrst_prev[k]) begin
                        chk($sformatf("nrst_low_len_ch%0d", k), nrst_len[k], RST_CYC);
                        nrst_len[k] = 0;
                    end
                end
                mon_en_prev   = CH_EN;
                mon_nrst_prev = CH_NRST;
            end
        end
    end

    // ---------------- reference model + full sequence run ----------------
    task automatic run_seq(input logic [NCH-1:0] mask, input string tag);
        logic [NCH-1:0] e_ok;
        logic [NCH-1:0] e_fail;
        int e_total;
        int e_att [NCH];
        int eq_ch[$];
        int eq_len[$];
        int first_en;
        int n;
        int first_n;
        int nq;
        // Cycles: one SCAN per channel plus the end-of-walk SCAN, FINISH,
        // and per enabled channel NEXT plus its attempts.
        e_ok     = '0;
        e_fail   = '0;
        e_total  = NCH + 2;
        first_en = -1;
        for (int k = 0; k < NCH; k++) begin
            e_att[k] = 0;
            if (mask[k]) begin
                if (first_en < 0) first_en = k;
                e_total += 1;
                for (int a = 0; a < MAXA; a++) begin
                    int dur;
                    bit good;
                    e_att[k] = a + 1;
                    if (rsp_code[k][a] == R_NONE || rsp_dly[k][a] > TO_CYC) begin
                        dur  = TO_CYC;
                        good = 1'b0;
                    end else begin
                        dur  = rsp_dly[k][a];
                        good = (rsp_code[k][a] == R_OK);
                    end
                    eq_ch.push_back(k);
                    eq_len.push_back(dur);
                    e_total += RST_CYC + 1 + dur;
                    if (good) begin
                        e_ok[k] = 1'b1;
                        break;
                    end
                    e_total += 1;
                    if (a == MAXA - 1) e_fail[k] = 1'b1;
                end
            end
        end

        clear_obs();
        CH_MASK = mask;
        START   = 1'b1;
        @(posedge CLK); #1;
        START   = 1'b0;
        CH_MASK = NCH'($urandom);
        chk({tag, ":busy_at_start"}, BUSY, 1);
        chk({tag, ":status_cleared"}, {SEQ_DONE, ABORTED, CH_OK, CH_FAIL}, 0);
        n       = 0;
        first_n = -1;
        while (!SEQ_DONE && n < e_total + 100) begin
            @(posedge CLK); #1;
            n++;
            if (first_n < 0 && CH_NRST != ALL1) first_n = n;
        end
        chk({tag, ":seq_cycles"}, n, e_total);
        chk({tag, ":ch_ok"}, CH_OK, e_ok);
        chk({tag, ":ch_fail"}, CH_FAIL, e_fail);
        chk({tag, ":aborted"}, ABORTED, 0);
        chk({tag, ":busy_end"}, BUSY, 0);
        if (first_en >= 0)
            chk({tag, ":first_nrst_lat"}, first_n, first_en + 1);
        chk({tag, ":en_pulses"}, obs_ch.size(), eq_ch.size());
        nq = (obs_ch.size() < eq_ch.size()) ? obs_ch.size() : eq_ch.size();
        for (int i = 0; i < nq; i++) begin
            chk($sformatf("%s:en_order%0d", tag, i), obs_ch[i], eq_ch[i]);
            chk($sformatf("%s:en_len%0d", tag, i), obs_len[i], eq_len[i]);
        end
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s:resets_ch%0d", tag, k), nrst_falls[k], e_att[k]);
            chk($sformatf("%s:enables_ch%0d", tag, k), en_rises[k], e_att[k]);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        ARST    = 1'b1;
        START   = 1'b0;
        ABORT   = 1'b0;
        CH_MASK = '0;
        set_all(R_OK, 10);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst:ch_en", CH_EN, 0);
        chk("rst:ch_nrst", CH_NRST, ALL1);
        chk("rst:samp_sel", SAMP_SEL, 0);
        chk("rst:flags", {BUSY, SEQ_DONE, ABORTED, CH_OK, CH_FAIL}, 0);
        ARST = 1'b0;
        @(posedge CLK); #1;

        // Channels 0,1,3 succeed after 500 cycles, channel 2 masked off.
        set_all(R_OK, 500);
        run_seq(4'b1011, "t1");

        // Channel 1 fails twice, then succeeds.
        set_all(R_OK, 30);
        rsp_code[1][0] = R_BAD; rsp_dly[1][0] = 40;
        rsp_code[1][1] = R_BAD; rsp_dly[1][1] = 7;
        rsp_code[1][2] = R_OK;  rsp_dly[1][2] = 55;
        run_seq(4'b1111, "t2");

        // Channel 2 never answers: three timeouts, then channel 3 runs.
        set_all(R_OK, 25);
        for (int a = 0; a < MAXA; a++) rsp_code[2][a] = R_NONE;
        run_seq(4'b1111, "t3");

        // DONE=11 on the very cycle the timeout expires counts as success.
        set_all(R_OK, TO_CYC);
        run_seq(4'b0001, "t_tie");

        // Abort while waiting on channel 1.
        set_all(R_OK, 15);
        for (int a = 0; a < MAXA; a++) rsp_code[1][a] = R_NONE;
        clear_obs();
        CH_MASK = '1;
        START   = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (!CH_EN[1] && n < 2000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("abort:reached_ch1", CH_EN[1], 1);
        repeat ($urandom_range(1, 50)) @(posedge CLK);
        #1;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        chk("abort:ch_en", CH_EN, 0);
        chk("abort:ch_nrst", CH_NRST, ALL1);
        chk("abort:busy", BUSY, 0);
        chk("abort:aborted", ABORTED, 1);
        chk("abort:seq_done", SEQ_DONE, 0);
        chk("abort:ch_ok_kept", CH_OK, 4'b0001);
        chk("abort:ch_fail", CH_FAIL, 0);
        // ABORT in IDLE is ignored and blocks START.
        ABORT = 1'b1;
        START = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("abort_idle:busy", BUSY, 0);
        chk("abort_idle:aborted_kept", ABORTED, 1);
        ABORT = 1'b0;
        START = 1'b0;
        @(posedge CLK); #1;

        // Empty mask with START held high; mask change mid-sequence ignored.
        set_all(R_OK, 5);
        clear_obs();
        CH_MASK = '0;
        START   = 1'b1;
        @(posedge CLK); #1;
        CH_MASK = NCH'($urandom_range(1, (1 << NCH) - 1));
        n = 0;
        while (!SEQ_DONE && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mask0:seq_cycles", n, NCH + 2);
        chk("mask0:status", {BUSY, ABORTED, CH_OK, CH_FAIL}, 0);
        chk("mask0:en_pulses", obs_ch.size(), 0);
        chk("mask0:resets", nrst_falls[0] + nrst_falls[1] + nrst_falls[2] + nrst_falls[3], 0);
        @(posedge CLK); #1;
        chk("mask0:restart_busy", BUSY, 1);
        chk("mask0:restart_seq_done", SEQ_DONE, 0);
        START = 1'b0;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        chk("scan_abort:busy", BUSY, 0);
        chk("scan_abort:aborted", ABORTED, 1);
        chk("scan_abort:nrst", CH_NRST, ALL1);
        @(posedge CLK); #1;

        // Asynchronous reset in the middle of WAIT on channel 2.
        set_all(R_NONE, 1);
        rsp_code[0][0] = R_OK; rsp_dly[0][0] = 5;
        clear_obs();
        CH_MASK = 4'b0101;
        START   = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        while (!CH_EN[2] && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("arst:reached_ch2", CH_EN[2], 1);
        chk("arst:ok_before", CH_OK, 4'b0001);
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        #2;
        ARST = 1'b1;
        #1;
        chk("arst:ch_en", CH_EN, 0);
        chk("arst:ch_nrst", CH_NRST, ALL1);
        chk("arst:samp_sel", SAMP_SEL, 0);
        chk("arst:flags", {BUSY, SEQ_DONE, ABORTED, CH_OK, CH_FAIL}, 0);
        @(negedge CLK);
        #2;
        ARST = 1'b0;
        @(posedge CLK); #1;
        chk("arst:idle_after", BUSY, 0);

        // Randomised sequences: random mask, codes and delays.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < NCH; k++)
                for (int a = 0; a < MAXA; a++) begin
                    rsp_code[k][a] = ($urandom_range(0, 9) < 6) ? R_OK : R_BAD;
                    rsp_dly[k][a]  = $urandom_range(1, 120);
                end
            run_seq(NCH'($urandom), $sformatf("rnd%0d", s));
            @(posedge CLK); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
